vga_pattern_writer: RTL

Raster-order pixel producer that fills the pixel FIFO drained by the VGA timing generator. It generates one 640x480 frame of 24-bit RGB words per frame period and pushes them with `wr_en` whenever the FIFO is not full. Pattern selection is latched per frame so the display never tears mid-frame. The block sits on the FIFO write side, in the same clock domain as its own logic. The write clock is faster than the 25 MHz read clock.

---
 rtl/vga_pattern_writer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/vga_pattern_writer.sv
// Raster-order 24-bit RGB pixel producer feeding the VGA pixel FIFO write side.
// Latency: first write one cycle after enable is registered; then one word/clock.
// Backpressure: wr_en = ~full combinationally in RUN; x/y hold while full is high.
module vga_pattern_writer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_rgb,
    input  logic        full,
    output logic        wr_en,
    output logic [23:0] pixelData,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam int         BAR_W  = H_ACTIVE / 8;
    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [1:0]  pat_q, pat_d;
    logic [23:0] rgb_q, rgb_d;
    logic        frame_done_q, frame_done_d;

    logic [2:0]  bar_idx;
    logic [9:0]  chk_s;
    logic [23:0] bar_rgb;

    assign wr_en      = (state_q == RUN) && !full;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

    // Raster position, frame counter and per-frame pattern latch.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        frame_cnt_d  = frame_cnt_q;
        pat_d        = pat_q;
        rgb_d        = rgb_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    pat_d   = pattern_sel;
                    rgb_d   = solid_rgb;
                    x_d     = 10'd0;
                    y_d     = 10'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (wr_en) begin
                    if (x_q == X_LAST) begin
                        x_d = 10'd0;
                        if (y_q == Y_LAST) begin
                            // Last pixel of the frame: the pattern may only change here.
                            y_d          = 10'd0;
                            frame_cnt_d  = frame_cnt_q + 8'd1;
                            frame_done_d = 1'b1;
                            if (enable) begin
                                pat_d = pattern_sel;
                                rgb_d = solid_rgb;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            y_d = y_q + 10'd1;
                        end
                    end else begin
                        x_d = x_q + 10'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            x_q          <= 10'd0;
            y_q          <= 10'd0;
            frame_cnt_q  <= 8'd0;
            pat_q        <= 2'd0;
            rgb_q        <= 24'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            frame_cnt_q  <= frame_cnt_d;
            pat_q        <= pat_d;
            rgb_q        <= rgb_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Colour-bar index by comparison against the bar boundaries (no divider).
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if ({22'd0, x_q} >= 32'(k * BAR_W)) begin
                bar_idx = bar_idx + 3'd1;
            end
        end
    end

    // Bar colour lookup.
    always_comb begin
        case (bar_idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    assign chk_s = x_q + {2'b00, frame_cnt_q};

    // Pixel value for the current raster position; zero outside RUN.
    always_comb begin
        pixelData = 24'd0;
        if (state_q == RUN) begin
            case (pat_q)
                2'd0:    pixelData = rgb_q;
                2'd1:    pixelData = bar_rgb;
                2'd2:    pixelData = {x_q[7:0], y_q[7:0], frame_cnt_q};
                default: pixelData = (chk_s[5] ^ y_q[5]) ? 24'hFFFFFF : 24'h000000;
            endcase
        end
    end

endmodule
